bcrypt_cmp_cfg_param: RTL and testbench
=======================================

BCRYPT_CMP_CFG_PARAM -- requirements
Module: bcrypt_cmp_cfg_param

Interface
REQ-001 SHALL have parameter HASH_NUM_WIDTH, default 9, giving log2 of the maximum comparator hash entries; legal range 1..15.
REQ-002 SHALL have parameter CMP_BYTES_LOG2, default 2, giving log2 of the comparator bytes per hash.
REQ-003 SHALL have parameter SALT_WORDS, default 4, giving the number of 32-bit salt words; legal range 1..15.
REQ-004 SHALL have parameter SETTING_MAX, default 19, giving the highest legal iteration-count bit index.
REQ-005 SHALL have one clock and a synchronous, active-high reset: port CLK (in, 1) and port RST (in, 1).
REQ-006 SHALL have the following ports:
- din  in  8  -- packet byte
- wr_en  in  1  -- byte valid
- full  out  1  -- input not accepted
- error  out  1  -- in ERROR state
- err_clear  in  1  -- leave ERROR state
- mode_cmp  in  1  -- comparator data present
- new_cmp_config  out  1  -- configuration ready
- cmp_config_applied  in  1  -- consumer acknowledge
- hash_count  out  HASH_NUM_WIDTH+1  -- number of hashes
- cmp_wr_addr  out  HASH_NUM_WIDTH+CMP_BYTES_LOG2  -- comparator write address
- cmp_wr_en  out  1  -- comparator write strobe
- cmp_din  out  8  -- comparator write data
- addr  in  4  -- read address
- dout  out  32  -- read data, combinational
- sign_extension_bug  out  1  -- applied subtype was 'x'

Function
REQ-007 Byte acceptance SHALL occur on (wr_en & ~full); a byte offered while full is high SHALL be ignored.
REQ-008 States SHALL be SALT, SUBTYPE, ITER, HCNT0, HCNT1, CMP_DATA, CHECKSUM, WAIT_APPLIED, MAGIC and ERROR.
REQ-009 SALT SHALL accept 4*SALT_WORDS bytes, little-endian per word; word i SHALL be stored at data[i+1]; the state SHALL then move to SUBTYPE.
REQ-010 SUBTYPE: 'x' SHALL set the pending bug flag to 1; 'a', 'b' or 'y' SHALL set it to 0; any other byte SHALL go to ERROR. Otherwise the state SHALL move to ITER.
REQ-011 ITER SHALL accept 4 bytes, little-endian, into data[0].
REQ-012 On the following byte (HCNT0), any bit above SETTING_MAX set in the iteration count SHALL go to ERROR; otherwise that byte is the hash_count low byte.
REQ-013 HCNT1 SHALL go to ERROR when any of the following holds: the 16-bit count exceeds 2^HASH_NUM_WIDTH; the count is 0 with mode_cmp=1; the count is nonzero with mode_cmp=0.
REQ-014 On HCNT1 success, mode_cmp=1 SHALL go to CMP_DATA; otherwise the next state SHALL be CHECKSUM if enabled, else WAIT_APPLIED.
REQ-015 CMP_DATA SHALL accept exactly hash_count<<CMP_BYTES_LOG2 bytes; cmp_wr_addr SHALL start at 0 and increment by 1 per byte.
REQ-016 Each CMP_DATA byte SHALL drive cmp_wr_en high for exactly one cycle, one cycle after acceptance, with cmp_din equal to that byte.
REQ-017 cmp_wr_en SHALL be 0 at all other times.
REQ-018 After the last CMP_DATA byte, the next state SHALL be CHECKSUM if enabled, else WAIT_APPLIED.
REQ-019 On entry to WAIT_APPLIED, new_cmp_config SHALL be 1 and full SHALL be 1.
REQ-020 In WAIT_APPLIED, cmp_config_applied=1 SHALL clear new_cmp_config and full, load sign_extension_bug from the pending flag, and move to MAGIC in the same cycle.
REQ-021 MAGIC: byte 0xCC SHALL move to SALT; any other byte SHALL go to ERROR.
REQ-022 ERROR SHALL hold full=1 and error=1.
REQ-023 err_clear in any state SHALL move to SALT, clear full and new_cmp_config, and discard any byte offered that cycle; err_clear wins over wr_en.
REQ-024 cmp_config_applied outside WAIT_APPLIED SHALL be ignored.
REQ-025 dout SHALL equal data[addr]; addresses above SALT_WORDS SHALL read 0.

Reset
REQ-026 RST SHALL set state=SALT, full=0, new_cmp_config=0, cmp_wr_en=0, cmp_wr_addr=0, hash_count=0, sign_extension_bug=0, and clear the byte and word counters.
REQ-027 RST mid-packet SHALL abandon the packet with no comparator write in the following cycle.
REQ-028 data[] SHALL be retained across RST (initialised to 0 at configuration).

Configuration
REQ-029 Macro BCRYPT_CMP_CFG_CHECKSUM_EN defined: the CHECKSUM state SHALL accept one byte equal to the XOR of all packet bytes from the first salt byte through the last preceding byte; a match SHALL move to WAIT_APPLIED and a mismatch SHALL go to ERROR without asserting new_cmp_config.
REQ-030 Macro BCRYPT_CMP_CFG_CHECKSUM_EN undefined: the CHECKSUM state and its logic SHALL be absent and no checksum byte SHALL be expected.

Verification
REQ-031 Defaults, mode_cmp=1, salt bytes 0x00..0x0F, 'b', iter 0x00000400, count 2, bytes 0x10..0x17 -> data[1]=0x03020100; data[0]=0x400; 8 cmp writes at addresses 0..7 with cmp_din 0x10..0x17; new_cmp_config=1; full=1.
REQ-032 Apply cmp_config_applied after REQ-031, then send 0xCC -> sign_extension_bug=0, state SALT; send subtype 'x' in the next packet -> sign_extension_bug=1 after apply.
REQ-033 Send iter 0x00100000 -> error=1 at HCNT0; then err_clear together with wr_en -> SALT, byte dropped, full=0.
REQ-034 HASH_NUM_WIDTH=9 with count 513, or count 0 with mode_cmp=1 -> ERROR; count 512 -> 2048 writes ending at address 0x7FF.
REQ-035 Assert RST after the 3rd CMP_DATA byte -> no further cmp_wr_en; a following complete packet is parsed correctly.
REQ-036 With BCRYPT_CMP_CFG_CHECKSUM_EN: correct XOR byte -> WAIT_APPLIED; corrupted XOR byte (one bit flipped) -> ERROR with new_cmp_config=0.

Source files
------------

// File: rtl/bcrypt_cmp_cfg_param.sv
// Parses bcrypt comparator configuration packets into salt/iteration words and comparator hash writes.
// Optional trailing XOR checksum byte: define BCRYPT_CMP_CFG_CHECKSUM_EN.
module bcrypt_cmp_cfg_param #(
  parameter int HASH_NUM_WIDTH = 9,
  parameter int CMP_BYTES_LOG2 = 2,
  parameter int SALT_WORDS     = 4,
  parameter int SETTING_MAX    = 19
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic [7:0]                               din,
  input  logic                                     wr_en,
  output logic                                     full,
  output logic                                     error,
  input  logic                                     err_clear,
  input  logic                                     mode_cmp,
  output logic                                     new_cmp_config,
  input  logic                                     cmp_config_applied,
  output logic [HASH_NUM_WIDTH:0]                  hash_count,
  output logic [HASH_NUM_WIDTH+CMP_BYTES_LOG2-1:0] cmp_wr_addr,
  output logic                                     cmp_wr_en,
  output logic [7:0]                               cmp_din,
  input  logic [3:0]                               addr,
  output logic [31:0]                              dout,
  output logic                                     sign_extension_bug
);
  // state           | meaning
  // ST_SALT         | collecting 4*SALT_WORDS salt bytes into data[1..]
  // ST_SUBTYPE      | one subtype byte ('a','b','y' or 'x')
  // ST_ITER         | 4 iteration-count bytes into data[0]
  // ST_HCNT0        | hash count low byte, iteration count range check
  // ST_HCNT1        | hash count high byte, count/mode check
  // ST_CMP_DATA     | comparator bytes, one write each
  // ST_CHECKSUM     | XOR checksum byte (optional build)
  // ST_WAIT_APPLIED | config ready, waiting for consumer acknowledge
  // ST_MAGIC        | trailing 0xCC marker
  // ST_ERROR        | stalled until err_clear

  localparam int AW = HASH_NUM_WIDTH + CMP_BYTES_LOG2;
  localparam int SALT_BYTES = 4 * SALT_WORDS;
  localparam logic [63:0] ITER_LEGAL = (64'd1 << (SETTING_MAX + 1)) - 64'd1;
  localparam logic [16:0] HCNT_MAX = 17'd1 << HASH_NUM_WIDTH;

  typedef enum logic [3:0] {
    ST_SALT, ST_SUBTYPE, ST_ITER, ST_HCNT0, ST_HCNT1, ST_CMP_DATA,
`ifdef BCRYPT_CMP_CFG_CHECKSUM_EN
    ST_CHECKSUM,
`endif
    ST_WAIT_APPLIED, ST_MAGIC, ST_ERROR
  } state_t;

`ifdef BCRYPT_CMP_CFG_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CHECKSUM;
`else
  localparam state_t ST_AFTER_DATA = ST_WAIT_APPLIED;
`endif

  state_t                      state_q, state_d;
  logic [5:0]                  byte_cnt_q, byte_cnt_d;
  logic [SALT_WORDS:0][31:0]   data_q, data_d;
  logic [7:0]                  hcnt_lo_q, hcnt_lo_d;
  logic [HASH_NUM_WIDTH:0]     hash_count_q, hash_count_d;
  logic [AW-1:0]               cmp_cnt_q, cmp_cnt_d;
  logic [AW-1:0]               cmp_wr_addr_q, cmp_wr_addr_d;
  logic                        cmp_wr_en_q, cmp_wr_en_d;
  logic [7:0]                  cmp_din_q, cmp_din_d;
  logic                        bug_pend_q, bug_pend_d;
  logic                        seb_q, seb_d;
`ifdef BCRYPT_CMP_CFG_CHECKSUM_EN
  logic [7:0]                  xor_q, xor_d;
`endif

  logic          accept;
  logic [15:0]   hcnt16;
  logic [AW:0]   cmp_total;
  logic [AW:0]   cmp_last;
  logic          iter_bad;

  assign accept    = wr_en & ~full & ~err_clear;
  assign hcnt16    = {din, hcnt_lo_q};
  assign cmp_total = (AW+1)'(hash_count_q) << CMP_BYTES_LOG2;
  assign cmp_last  = cmp_total - (AW+1)'(1);
  assign iter_bad  = |({32'd0, data_q[0]} & ~ITER_LEGAL);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_SALT;
      byte_cnt_q    <= '0;
      hcnt_lo_q     <= '0;
      hash_count_q  <= '0;
      cmp_cnt_q     <= '0;
      cmp_wr_addr_q <= '0;
      cmp_wr_en_q   <= 1'b0;
      cmp_din_q     <= '0;
      bug_pend_q    <= 1'b0;
      seb_q         <= 1'b0;
`ifdef BCRYPT_CMP_CFG_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      hcnt_lo_q     <= hcnt_lo_d;
      hash_count_q  <= hash_count_d;
      cmp_cnt_q     <= cmp_cnt_d;
      cmp_wr_addr_q <= cmp_wr_addr_d;
      cmp_wr_en_q   <= cmp_wr_en_d;
      cmp_din_q     <= cmp_din_d;
      bug_pend_q    <= bug_pend_d;
      seb_q         <= seb_d;
`ifdef BCRYPT_CMP_CFG_CHECKSUM_EN
      xor_q         <= xor_d;
`endif
    end
  end

  // Salt and iteration words survive RST so the consumer can still read them back.
  always_ff @(posedge CLK) begin
    data_q <= data_d;
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    data_d        = data_q;
    hcnt_lo_d     = hcnt_lo_q;
    hash_count_d  = hash_count_q;
    cmp_cnt_d     = cmp_cnt_q;
    cmp_wr_addr_d = cmp_wr_addr_q;
    cmp_wr_en_d   = 1'b0;
    cmp_din_d     = cmp_din_q;
    bug_pend_d    = bug_pend_q;
    seb_d         = seb_q;
`ifdef BCRYPT_CMP_CFG_CHECKSUM_EN
    xor_d = xor_q;
    if (accept) xor_d = (state_q == ST_SALT && byte_cnt_q == '0) ? din : (xor_q ^ din);
`endif
    if (err_clear) begin
      state_d    = ST_SALT;
      byte_cnt_d = '0;
    end else begin
      case (state_q)
        ST_SALT: if (accept) begin
          for (int i = 1; i <= SALT_WORDS; i++)
            if (byte_cnt_q[5:2] == 4'(i - 1)) data_d[i][{byte_cnt_q[1:0], 3'b000} +: 8] = din;
          if (byte_cnt_q == 6'(SALT_BYTES - 1)) begin
            state_d    = ST_SUBTYPE;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end
        ST_SUBTYPE: if (accept) begin
          state_d = ST_ITER;
          case (din)
            8'h78:               bug_pend_d = 1'b1;
            8'h61, 8'h62, 8'h79: bug_pend_d = 1'b0;
            default:             state_d = ST_ERROR;
          endcase
        end
        ST_ITER: if (accept) begin
          data_d[0][{byte_cnt_q[1:0], 3'b000} +: 8] = din;
          if (byte_cnt_q[1:0] == 2'd3) begin
            state_d    = ST_HCNT0;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end
        ST_HCNT0: if (accept) begin
          if (iter_bad) begin
            state_d = ST_ERROR;
          end else begin
            hcnt_lo_d = din;
            state_d   = ST_HCNT1;
          end
        end
        ST_HCNT1: if (accept) begin
          if (({1'b0, hcnt16} > HCNT_MAX) || (mode_cmp && hcnt16 == '0) ||
              (!mode_cmp && hcnt16 != '0)) begin
            state_d = ST_ERROR;
          end else begin
            hash_count_d = hcnt16[HASH_NUM_WIDTH:0];
            cmp_cnt_d    = '0;
            state_d      = mode_cmp ? ST_CMP_DATA : ST_AFTER_DATA;
          end
        end
        ST_CMP_DATA: if (accept) begin
          cmp_wr_en_d   = 1'b1;
          cmp_din_d     = din;
          cmp_wr_addr_d = cmp_cnt_q;
          cmp_cnt_d     = cmp_cnt_q + AW'(1);
          if ({1'b0, cmp_cnt_q} == cmp_last) state_d = ST_AFTER_DATA;
        end
`ifdef BCRYPT_CMP_CFG_CHECKSUM_EN
        ST_CHECKSUM: if (accept) state_d = (din == xor_q) ? ST_WAIT_APPLIED : ST_ERROR;
`endif
        ST_WAIT_APPLIED: if (cmp_config_applied) begin
          seb_d   = bug_pend_q;
          state_d = ST_MAGIC;
        end
        ST_MAGIC: if (accept) begin
          state_d    = (din == 8'hCC) ? ST_SALT : ST_ERROR;
          byte_cnt_d = '0;
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_ERROR;
      endcase
    end
  end

  always_comb begin
    full           = (state_q == ST_WAIT_APPLIED) || (state_q == ST_ERROR);
    error          = (state_q == ST_ERROR);
    new_cmp_config = (state_q == ST_WAIT_APPLIED);
    dout           = '0;
    for (int i = 0; i <= SALT_WORDS; i++)
      if (addr == 4'(i)) dout = data_q[i];
  end

  assign hash_count         = hash_count_q;
  assign cmp_wr_addr        = cmp_wr_addr_q;
  assign cmp_wr_en          = cmp_wr_en_q;
  assign cmp_din            = cmp_din_q;
  assign sign_extension_bug = seb_q;

endmodule

// File: tb/tb_bcrypt_cmp_cfg_param.sv
// Randomized packet bench for bcrypt_cmp_cfg_param with a packet-level reference model.
module tb_bcrypt_cmp_cfg_param;
  localparam int HNW = 9, CBL = 2, SW = 4, SMAX = 19;
`ifdef BCRYPT_CMP_CFG_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST, wr_en, full, error, err_clear, mode_cmp, new_cmp_config;
  logic cmp_config_applied, cmp_wr_en, sign_extension_bug;
  logic [7:0] din, cmp_din;
  logic [HNW:0] hash_count;
  logic [HNW+CBL-1:0] cmp_wr_addr;
  logic [3:0] addr;
  logic [31:0] dout;

  always #5 CLK = ~CLK;

  bcrypt_cmp_cfg_param dut (
    .CLK(CLK), .RST(RST), .din(din), .wr_en(wr_en), .full(full), .error(error),
    .err_clear(err_clear), .mode_cmp(mode_cmp), .new_cmp_config(new_cmp_config),
    .cmp_config_applied(cmp_config_applied), .hash_count(hash_count),
    .cmp_wr_addr(cmp_wr_addr), .cmp_wr_en(cmp_wr_en), .cmp_din(cmp_din),
    .addr(addr), .dout(dout), .sign_extension_bug(sign_extension_bug)
  );

  int n_cmp = 0, n_bad = 0;
  int exp_wr[$];
  logic [31:0] exp_data [16];
  logic [7:0] pkt[$];
  bit pkt_ok;
  int exp_hcount = 0;
  bit exp_seb = 0, exp_pend = 0;
  logic [7:0] subs [4] = '{8'h61, 8'h62, 8'h78, 8'h79};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every comparator write must match the next expected (address, byte) pair.
  always @(negedge CLK) begin
    int e;
    if (cmp_wr_en === 1'b1) begin
      if (exp_wr.size() == 0) check("cmp_wr_en spurious", cmp_wr_en, 1'b0);
      else begin
        e = exp_wr.pop_front();
        check("cmp_wr_addr", cmp_wr_addr, e >> 8);
        check("cmp_din", cmp_din, e & 255);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    din = b;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_max);
    for (int i = lo; i < hi && i < pkt.size(); i++) begin
      if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
      push(pkt[i]);
    end
  endtask

  // Builds one packet from its fields and records what the parser must produce.
  task automatic build(input bit mode, input int cnt, input logic [7:0] sub,
                       input logic [31:0] iter, input bit seq, input bit corrupt);
    logic [7:0] b, x;
    bit sub_ok, iter_ok, cnt_ok;
    pkt.delete();
    for (int i = 0; i < 4*SW; i++) begin
      b = seq ? 8'(i) : 8'($urandom);
      pkt.push_back(b);
    end
    for (int w = 0; w < SW; w++)
      exp_data[w+1] = pkt[4*w] + (pkt[4*w+1] << 8) + (pkt[4*w+2] << 16) + (pkt[4*w+3] << 24);
    pkt.push_back(sub);
    for (int k = 0; k < 4; k++) pkt.push_back(8'((iter >> (8*k)) & 255));
    pkt.push_back(8'(cnt & 255));
    pkt.push_back(8'((cnt >> 8) & 255));
    sub_ok  = (sub == 8'h61) || (sub == 8'h62) || (sub == 8'h78) || (sub == 8'h79);
    iter_ok = (64'(iter) >> (SMAX + 1)) == 0;
    cnt_ok  = (cnt <= (1 << HNW)) && (mode ? cnt != 0 : cnt == 0);
    pkt_ok  = sub_ok && iter_ok && cnt_ok;
    if (sub_ok) exp_data[0] = iter;
    if (pkt_ok) begin
      exp_hcount = cnt;
      exp_pend = (sub == 8'h78);
      if (mode)
        for (int i = 0; i < (cnt << CBL); i++) begin
          b = seq ? 8'(16 + i) : 8'($urandom);
          pkt.push_back(b);
          exp_wr.push_back((i << 8) | int'(b));
        end
      if (CSUM_EN) begin
        x = 8'h00;
        foreach (pkt[i]) x = x ^ pkt[i];
        pkt.push_back(corrupt ? (x ^ 8'h04) : x);
        if (corrupt) pkt_ok = 1'b0;
      end
    end else begin
      repeat (4) pkt.push_back(8'($urandom));
    end
    mode_cmp = mode;
  endtask

  task automatic check_dout();
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      check($sformatf("dout[%0d]", a), dout, (a <= SW) ? exp_data[a] : 32'h0);
    end
    @(negedge CLK);
  endtask

  task automatic check_after();
    idle(2);
    check("writes outstanding", exp_wr.size(), 0);
    exp_wr.delete();
    check("full", full, 1'b1);
    check("error", error, !pkt_ok);
    check("new_cmp_config", new_cmp_config, pkt_ok);
    check("hash_count", hash_count, exp_hcount);
    check_dout();
  endtask

  task automatic apply_and_magic(input logic [7:0] magic);
    cmp_config_applied = 1'b1;
    @(negedge CLK);
    cmp_config_applied = 1'b0;
    exp_seb = exp_pend;
    check("new_cmp_config after apply", new_cmp_config, 1'b0);
    check("full after apply", full, 1'b0);
    check("sign_extension_bug", sign_extension_bug, exp_seb);
    push(magic);
    idle(1);
    check("error after magic", error, magic != 8'hCC);
    check("full after magic", full, magic != 8'hCC);
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    wr_en = 1'b1;
    din = 8'($urandom);
    @(negedge CLK);
    err_clear = 1'b0;
    wr_en = 1'b0;
    check("error after clear", error, 1'b0);
    check("full after clear", full, 1'b0);
    check("new_cmp_config after clear", new_cmp_config, 1'b0);
  endtask

  initial begin
    bit mode;
    int cnt, kind;
    logic [7:0] sub;
    logic [31:0] iter;
    int bad_mode [3] = '{1, 1, 0};
    int bad_cnt  [3] = '{513, 0, 3};
    foreach (exp_data[i]) exp_data[i] = 32'h0;
    RST = 1'b1; wr_en = 1'b0; din = 8'h00; err_clear = 1'b0; mode_cmp = 1'b0;
    cmp_config_applied = 1'b0; addr = 4'd0;
    idle(3);
    RST = 1'b0;
    idle(1);
    check("reset full", full, 1'b0);
    check("reset error", error, 1'b0);
    check("reset new_cmp_config", new_cmp_config, 1'b0);
    check("reset cmp_wr_en", cmp_wr_en, 1'b0);
    check("reset cmp_wr_addr", cmp_wr_addr, 0);
    check("reset hash_count", hash_count, 0);
    check("reset sign_extension_bug", sign_extension_bug, 1'b0);

    // Reference packet with hand-computed expectations.
    build(1'b1, 2, 8'h62, 32'h0000_0400, 1'b1, 1'b0);
    send_range(0, pkt.size(), 0);
    check_after();
    addr = 4'd1; #1 check("pin data[1]", dout, 32'h0302_0100);
    addr = 4'd2; #1 check("pin data[2]", dout, 32'h0706_0504);
    addr = 4'd0; #1 check("pin data[0]", dout, 32'h0000_0400);
    @(negedge CLK);
    check("pin hash_count", hash_count, 2);
    check("pin last cmp_wr_addr", cmp_wr_addr, 7);
    apply_and_magic(8'hCC);

    // Subtype 'x' sets the bug flag once applied.
    build(1'b1, 1, 8'h78, $urandom & 32'h000F_FFFF, 1'b0, 1'b0);
    send_range(0, pkt.size(), 2);
    check_after();
    apply_and_magic(8'hCC);
    check("pin bug after x", sign_extension_bug, 1'b1);

    // Acknowledge outside WAIT_APPLIED is ignored.
    build(1'b0, 0, 8'h61, $urandom & 32'h000F_FFFF, 1'b0, 1'b0);
    send_range(0, 10, 1);
    cmp_config_applied = 1'b1;
    @(negedge CLK);
    cmp_config_applied = 1'b0;
    check("early apply bug", sign_extension_bug, exp_seb);
    check("early apply full", full, 1'b0);
    send_range(10, pkt.size(), 1);
    check_after();
    check("bug held before apply", sign_extension_bug, exp_seb);
    apply_and_magic(8'hCC);

    // Iteration count above SETTING_MAX stops at the first hash-count byte.
    build(1'b0, 0, 8'h62, 32'h0010_0000, 1'b1, 1'b0);
    send_range(0, 4*SW + 6, 0);
    idle(1);
    check("iter error", error, 1'b1);
    check("iter error full", full, 1'b1);
    clear_err();
    build(1'b1, 1, 8'h79, $urandom & 32'h000F_FFFF, 1'b0, 1'b0);
    send_range(0, pkt.size(), 1);
    check_after();
    apply_and_magic(8'hCC);

    // Illegal hash counts and subtype.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) build(bad_mode[k] != 0, bad_cnt[k], 8'h62, 32'h0000_1000, 1'b0, 1'b0);
      else build(1'b1, 1, 8'h7A, 32'h0000_1000, 1'b0, 1'b0);
      send_range(0, pkt.size(), 1);
      check_after();
      clear_err();
    end

    // Largest table: 512 hashes, 2048 writes.
    build(1'b1, 512, 8'h79, $urandom & 32'h000F_FFFF, 1'b0, 1'b0);
    send_range(0, pkt.size(), 0);
    check_after();
    check("pin 512 last addr", cmp_wr_addr, 11'h7FF);
    check("pin 512 hash_count", hash_count, 512);
    apply_and_magic(8'hCC);

    // Reset mid comparator data: no further writes, data words kept.
    build(1'b1, 2, 8'h61, 32'h0000_2222, 1'b1, 1'b0);
    while (exp_wr.size() > 3) void'(exp_wr.pop_back());
    send_range(0, 4*SW + 7 + 3, 0);
    RST = 1'b1; wr_en = 1'b1; din = 8'h55;
    @(negedge CLK);
    RST = 1'b0; wr_en = 1'b0;
    exp_hcount = 0; exp_seb = 1'b0;
    idle(2);
    check("rst writes outstanding", exp_wr.size(), 0);
    check("rst hash_count", hash_count, exp_hcount);
    check("rst cmp_wr_addr", cmp_wr_addr, 0);
    check("rst full", full, 1'b0);
    check("rst bug", sign_extension_bug, exp_seb);
    check_dout();
    build(1'b1, 2, 8'h62, $urandom & 32'h000F_FFFF, 1'b0, 1'b0);
    send_range(0, pkt.size(), 1);
    check_after();
    apply_and_magic(8'hCC);

`ifdef BCRYPT_CMP_CFG_CHECKSUM_EN
    build(1'b1, 1, 8'h62, 32'h0000_0400, 1'b0, 1'b1);
    send_range(0, pkt.size(), 0);
    check_after();
    clear_err();
    build(1'b1, 1, 8'h62, 32'h0000_0400, 1'b0, 1'b0);
    send_range(0, pkt.size(), 0);
    check_after();
    apply_and_magic(8'hCC);
`endif

    // Randomized packets, good and bad.
    for (int n = 0; n < 30; n++) begin
      mode = 1'($urandom);
      cnt = mode ? 1 + int'($urandom_range(4, 0)) : 0;
      sub = subs[$urandom_range(3, 0)];
      iter = $urandom & 32'h000F_FFFF;
      kind = int'($urandom_range(7, 0));
      case (kind)
        0: sub = 8'h63;
        1: iter = iter | (32'd1 << (SMAX + 1 + int'($urandom_range(31 - SMAX - 1, 0))));
        2: cnt = mode ? 0 : 1;
        3: begin mode = 1'b1; cnt = (1 << HNW) + 1 + int'($urandom_range(3, 0)); end
        default: ;
      endcase
      build(mode, cnt, sub, iter, 1'b0, kind == 4);
      send_range(0, pkt.size(), 3);
      check_after();
      if (pkt_ok) begin
        if ($urandom_range(1, 0) == 1) begin
          repeat (3) push(8'($urandom));
          check("bytes ignored while full", new_cmp_config, 1'b1);
        end
        apply_and_magic(kind == 5 ? 8'h33 : 8'hCC);
        if (kind == 5) clear_err();
      end else begin
        clear_err();
      end
    end

    idle(2);
    check("final writes outstanding", exp_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
